decode_hazard_ctl: RTL and testbench

Hazard and forwarding controller for the decode stage. It tracks the destination registers of the three instructions in flight past decode (EX, MEM, WB) in an internal scoreboard. From that it drives the decode operand forwarding selects `fwd_A`/`fwd_B`, and it stalls the front end when a decode-time operand is not yet available. It also freezes with the rest of the pipeline on a memory stall and counts stall cycles.

---
 rtl/decode_hazard_ctl.sv | 145 ++++++++++++++
 tb/tb_decode_hazard_ctl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_hazard_ctl.sv
// rtl/decode_hazard_ctl.sv - decode-stage hazard scoreboard, forwarding selects and stall control
module decode_hazard_ctl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [15:0]      id_instr,
    input  logic             id_use_a,
    input  logic             id_use_b,
    input  logic             id_reg_write,
    input  logic [1:0]       id_reg_dst,
    input  logic             id_mem_read,
    input  logic             mem_stall,
    output logic [1:0]       fwd_A,
    output logic [1:0]       fwd_B,
    output logic             stall_id,
    output logic             bubble_ex,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    // Scoreboard slots: one per instruction in flight past decode.
    logic       ex_v_q,   ex_wr_q,   ex_ld_q;
    logic [2:0] ex_dst_q;
    logic       mem_v_q,  mem_wr_q,  mem_ld_q;
    logic [2:0] mem_dst_q;
    logic       wb_v_q,   wb_wr_q,   wb_ld_q;
    logic [2:0] wb_dst_q;

    logic       ex_v_d,   ex_wr_d,   ex_ld_d;
    logic [2:0] ex_dst_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [2:0] rs, rt, rd, id_dst;
    logic       ex_hit_a,  mem_hit_a,  wb_hit_a;
    logic       ex_hit_b,  mem_hit_b,  wb_hit_b;
    logic [2:0] res_a, res_b;
    logic       need_a, need_b;

    // Opcode bits and the WB load flag never influence a decision.
    logic unused_bits;
    assign unused_bits = ^{id_instr[15:11], id_instr[1:0], wb_ld_q};

    assign rs = id_instr[10:8];
    assign rt = id_instr[7:5];
    assign rd = id_instr[4:2];

    // Resolve {need_stall, fwd} for one operand; the youngest hit wins.
    function automatic logic [2:0] resolve(
        input logic use_op,
        input logic ex_hit,
        input logic mem_hit,
        input logic mem_ld,
        input logic wb_hit
    );
        logic [2:0] r;
        r = {1'b0, FWD_RF};
        if (use_op) begin
            if (ex_hit)               r = {1'b1, FWD_RF};
            else if (mem_hit && mem_ld) r = {1'b1, FWD_RF};
            else if (mem_hit)         r = {1'b0, FWD_EXMEM};
            else if (wb_hit)          r = {1'b0, FWD_MEMWB};
        end
        return r;
    endfunction

    // Destination register of the instruction currently in decode.
    always_comb begin
        id_dst = rd;
        case (id_reg_dst)
            2'd0:    id_dst = rd;
            2'd1:    id_dst = rt;
            2'd2:    id_dst = rs;
            default: id_dst = 3'd7;
        endcase
    end

    // Slot hit detection against both decode operands.
    always_comb begin
        ex_hit_a  = ex_v_q  & ex_wr_q  & (ex_dst_q  == rs);
        mem_hit_a = mem_v_q & mem_wr_q & (mem_dst_q == rs);
        wb_hit_a  = wb_v_q  & wb_wr_q  & (wb_dst_q  == rs);
        ex_hit_b  = ex_v_q  & ex_wr_q  & (ex_dst_q  == rt);
        mem_hit_b = mem_v_q & mem_wr_q & (mem_dst_q == rt);
        wb_hit_b  = wb_v_q  & wb_wr_q  & (wb_dst_q  == rt);
    end

    // Per-operand forwarding and stall need; the global freeze masks the stall.
    always_comb begin
        res_a     = resolve(id_use_a, ex_hit_a, mem_hit_a, mem_ld_q, wb_hit_a);
        res_b     = resolve(id_use_b, ex_hit_b, mem_hit_b, mem_ld_q, wb_hit_b);
        need_a    = res_a[2];
        need_b    = res_b[2];
        fwd_A     = res_a[1:0];
        fwd_B     = res_b[1:0];
        stall_id  = id_valid & (need_a | need_b) & ~mem_stall;
        bubble_ex = stall_id;
    end

    // Entry offered to the EX slot (a bubble while decode is stalled) and counter next state.
    always_comb begin
        ex_v_d   = id_valid & ~stall_id;
        ex_wr_d  = id_reg_write;
        ex_ld_d  = id_mem_read;
        ex_dst_d = id_dst;
        cnt_d    = cnt_q;
        if (stall_id && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Scoreboard shift (held during a memory stall) and stall counter; reset wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_v_q  <= 1'b0;
            mem_v_q <= 1'b0;
            wb_v_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (!mem_stall) begin
                wb_v_q    <= mem_v_q;
                wb_wr_q   <= mem_wr_q;
                wb_ld_q   <= mem_ld_q;
                wb_dst_q  <= mem_dst_q;
                mem_v_q   <= ex_v_q;
                mem_wr_q  <= ex_wr_q;
                mem_ld_q  <= ex_ld_q;
                mem_dst_q <= ex_dst_q;
                ex_v_q    <= ex_v_d;
                ex_wr_q   <= ex_wr_d;
                ex_ld_q   <= ex_ld_d;
                ex_dst_q  <= ex_dst_d;
            end
            cnt_q <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_decode_hazard_ctl.sv
// tb/tb_decode_hazard_ctl.sv - self-checking bench for decode_hazard_ctl
module tb_decode_hazard_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [15:0] id_instr;
    logic        id_use_a, id_use_b, id_reg_write, id_mem_read, mem_stall;
    logic [1:0]  id_reg_dst;

    logic [1:0]  fa16, fb16, fa4, fb4;
    logic        st16, bx16, st4, bx4;
    logic [15:0] cnt16;
    logic [3:0]  cnt4;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    decode_hazard_ctl #(.CNT_W(16)) dut16 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
        .id_use_a(id_use_a), .id_use_b(id_use_b), .id_reg_write(id_reg_write),
        .id_reg_dst(id_reg_dst), .id_mem_read(id_mem_read), .mem_stall(mem_stall),
        .fwd_A(fa16), .fwd_B(fb16), .stall_id(st16), .bubble_ex(bx16), .stall_cnt(cnt16)
    );

    decode_hazard_ctl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
        .id_use_a(id_use_a), .id_use_b(id_use_b), .id_reg_write(id_reg_write),
        .id_reg_dst(id_reg_dst), .id_mem_read(id_mem_read), .mem_stall(mem_stall),
        .fwd_A(fa4), .fwd_B(fb4), .stall_id(st4), .bubble_ex(bx4), .stall_cnt(cnt4)
    );

    typedef struct {
        logic       rst_n, v;
        logic [2:0] rs, rt, rd;
        logic       ua, ub, rw;
        logic [1:0] rdst;
        logic       mr, ms, chk;
        logic [1:0] fa, fb;
        logic       st;
        int         cnt;
    } vec_t;

    typedef struct {
        logic       v, wr, ld;
        logic [2:0] dst;
    } inflight_t;

    vec_t      tbl[$];
    inflight_t pipe[$];
    int        model_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    task automatic drive(input logic rst_n, input logic v, input logic [2:0] rs, input logic [2:0] rt,
                         input logic [2:0] rd, input logic ua, input logic ub, input logic rw,
                         input logic [1:0] rdst, input logic mr, input logic ms);
        rst          = rst_n;
        id_valid     = v;
        id_instr     = {5'b10101, rs, rt, rd, 2'b11};
        id_use_a     = ua;
        id_use_b     = ub;
        id_reg_write = rw;
        id_reg_dst   = rdst;
        id_mem_read  = mr;
        mem_stall    = ms;
        #1;
    endtask

    function automatic vec_t mkv(input logic rst_n, input logic v, input int rs, input int rt, input int rd,
                                 input logic ua, input logic ub, input logic rw, input int rdst,
                                 input logic mr, input logic ms, input logic c, input int fa, input int fb,
                                 input logic st, input int cnt);
        vec_t r;
        r.rst_n = rst_n; r.v = v; r.rs = 3'(rs); r.rt = 3'(rt); r.rd = 3'(rd);
        r.ua = ua; r.ub = ub; r.rw = rw; r.rdst = 2'(rdst); r.mr = mr; r.ms = ms;
        r.chk = c; r.fa = 2'(fa); r.fb = 2'(fb); r.st = st; r.cnt = cnt;
        return r;
    endfunction

    // Reference: operand availability by age of the youngest in-flight producer.
    function automatic logic [2:0] ref_operand(input logic used, input logic [2:0] src);
        if (!used) return 3'b000;
        for (int age = 0; age < 3; age++) begin
            if (pipe[age].v && pipe[age].wr && pipe[age].dst == src) begin
                if (age == 0) return 3'b100;
                if (age == 1) return pipe[age].ld ? 3'b100 : 3'b010;
                return 3'b001;
            end
        end
        return 3'b000;
    endfunction

    initial begin
        // rst v  rs rt rd ua ub rw dst mr ms chk fa fb st cnt
        tbl.push_back(mkv(0,1, 3,0,0, 1,0,0,0, 0,0, 0, 0,0,0,0));
        tbl.push_back(mkv(0,1, 3,0,0, 1,0,0,0, 0,0, 1, 0,0,0,0));
        tbl.push_back(mkv(1,1, 0,0,3, 0,0,1,0, 0,0, 1, 0,0,0,0));
        tbl.push_back(mkv(1,1, 3,0,0, 1,0,0,0, 0,0, 1, 0,0,1,0));
        tbl.push_back(mkv(1,1, 3,0,0, 1,0,0,0, 0,0, 1, 2,0,0,1));
        tbl.push_back(mkv(1,1, 0,5,0, 0,0,1,1, 1,0, 1, 0,0,0,1));
        tbl.push_back(mkv(1,1, 5,0,0, 1,0,0,0, 0,0, 1, 0,0,1,1));
        tbl.push_back(mkv(1,1, 5,0,0, 1,0,0,0, 0,0, 1, 0,0,1,2));
        tbl.push_back(mkv(1,1, 5,0,0, 1,0,0,0, 0,0, 1, 1,0,0,3));
        tbl.push_back(mkv(1,1, 0,2,0, 0,0,1,1, 0,0, 1, 0,0,0,3));
        tbl.push_back(mkv(1,1, 0,0,2, 0,0,1,0, 0,0, 1, 0,0,0,3));
        tbl.push_back(mkv(1,1, 2,0,0, 1,0,0,0, 0,0, 1, 0,0,1,3));
        tbl.push_back(mkv(1,1, 2,0,0, 1,0,0,0, 0,0, 1, 2,0,0,4));
        tbl.push_back(mkv(1,1, 0,4,0, 0,0,1,1, 1,0, 1, 0,0,0,4));
        tbl.push_back(mkv(1,1, 4,0,0, 1,0,0,0, 0,1, 1, 0,0,0,4));
        tbl.push_back(mkv(1,1, 4,0,0, 1,0,0,0, 0,1, 1, 0,0,0,4));
        tbl.push_back(mkv(1,1, 4,0,0, 1,0,0,0, 0,1, 1, 0,0,0,4));
        tbl.push_back(mkv(1,1, 4,0,0, 1,0,0,0, 0,0, 1, 0,0,1,4));
        tbl.push_back(mkv(1,1, 4,0,0, 1,0,0,0, 0,0, 1, 0,0,1,5));
        tbl.push_back(mkv(1,1, 4,0,0, 1,0,0,0, 0,0, 1, 1,0,0,6));
        tbl.push_back(mkv(1,1, 0,0,0, 0,0,1,3, 0,0, 1, 0,0,0,6));
        tbl.push_back(mkv(1,1, 7,7,0, 1,1,0,0, 0,0, 1, 0,0,1,6));
        tbl.push_back(mkv(1,1, 7,7,0, 1,1,0,0, 0,0, 1, 2,2,0,7));
        tbl.push_back(mkv(1,1, 0,6,0, 0,0,1,1, 1,0, 1, 0,0,0,7));
        tbl.push_back(mkv(1,1, 0,0,0, 0,0,0,0, 0,0, 1, 0,0,0,7));
        tbl.push_back(mkv(1,1, 6,0,0, 1,0,0,0, 0,0, 1, 0,0,1,7));
        tbl.push_back(mkv(1,1, 6,0,0, 1,0,0,0, 0,0, 1, 1,0,0,8));
        tbl.push_back(mkv(1,1, 0,1,0, 0,0,1,1, 1,0, 1, 0,0,0,8));
        tbl.push_back(mkv(1,0, 0,1,0, 0,1,0,0, 0,0, 1, 0,0,0,8));
        tbl.push_back(mkv(0,1, 0,1,0, 0,1,0,0, 0,0, 1, 0,0,1,8));
        tbl.push_back(mkv(1,1, 0,1,0, 0,1,0,0, 0,0, 1, 0,0,0,0));

        // Directed sequences from the table, one row per clock cycle.
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst_n, tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].ua, tbl[i].ub,
                  tbl[i].rw, tbl[i].rdst, tbl[i].mr, tbl[i].ms);
            if (tbl[i].chk) begin
                chk($sformatf("vec%0d fwd_A", i), 32'(fa16), 32'(tbl[i].fa));
                chk($sformatf("vec%0d fwd_B", i), 32'(fb16), 32'(tbl[i].fb));
                chk($sformatf("vec%0d stall_id", i), 32'(st16), 32'(tbl[i].st));
                chk($sformatf("vec%0d bubble_ex", i), 32'(bx16), 32'(tbl[i].st));
                chk($sformatf("vec%0d stall_cnt", i), 32'(cnt16), 32'(tbl[i].cnt));
            end
            @(negedge clk);
        end

        // Randomized traffic against the age-based reference model.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        pipe.delete();
        for (int k = 0; k < 3; k++) pipe.push_back('{v: 1'b0, wr: 1'b0, ld: 1'b0, dst: 3'd0});
        model_cnt = 0;
        for (int n = 0; n < 600; n++) begin
            logic       r_n, v, ua, ub, rw, mr, ms, est;
            logic [2:0] rs, rt, rd, dst, ra, rb;
            logic [1:0] rdst;
            inflight_t  e;
            r_n  = ($urandom_range(0, 49) != 0);
            v    = ($urandom_range(0, 3) != 0);
            rs   = 3'($urandom_range(0, 3));
            rt   = 3'($urandom_range(0, 3));
            rd   = 3'($urandom_range(0, 3));
            ua   = 1'($urandom);
            ub   = 1'($urandom);
            rw   = ($urandom_range(0, 3) != 0);
            rdst = 2'($urandom);
            mr   = 1'($urandom);
            ms   = ($urandom_range(0, 4) == 0);
            dst  = (rdst == 2'd0) ? rd : (rdst == 2'd1) ? rt : (rdst == 2'd2) ? rs : 3'd7;
            drive(r_n, v, rs, rt, rd, ua, ub, rw, rdst, mr, ms);
            ra  = ref_operand(ua, rs);
            rb  = ref_operand(ub, rt);
            est = v && (ra[2] || rb[2]) && !ms;
            chk("rnd fwd_A", 32'(fa16), 32'(ra[1:0]));
            chk("rnd fwd_B", 32'(fb16), 32'(rb[1:0]));
            chk("rnd stall_id", 32'(st16), 32'(est));
            chk("rnd bubble_ex", 32'(bx16), 32'(est));
            chk("rnd stall_cnt16", 32'(cnt16), 32'((model_cnt > 65535) ? 65535 : model_cnt));
            chk("rnd stall_cnt4", 32'(cnt4), 32'((model_cnt > 15) ? 15 : model_cnt));
            chk("rnd w4 outputs", 32'({fa4, fb4, st4, bx4}), 32'({ra[1:0], rb[1:0], est, est}));
            if (!r_n) begin
                for (int k = 0; k < 3; k++) pipe[k].v = 1'b0;
                model_cnt = 0;
            end else if (!ms) begin
                e.v = v && !est; e.wr = rw; e.ld = mr; e.dst = dst;
                pipe.push_front(e);
                void'(pipe.pop_back());
                if (est) model_cnt++;
            end
            @(negedge clk);
        end

        // Counter saturation: ten load-use pairs give twenty stall cycles.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        for (int p = 0; p < 10; p++) begin
            drive(1, 1, 0, 5, 0, 0, 0, 1, 1, 1, 0);
            @(negedge clk);
            for (int c = 0; c < 3; c++) begin
                drive(1, 1, 5, 0, 0, 1, 0, 0, 0, 0, 0);
                chk($sformatf("sat pair%0d cyc%0d stall_id", p, c), 32'(st4), 32'((c < 2) ? 1 : 0));
                @(negedge clk);
            end
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("sat stall_cnt4", 32'(cnt4), 32'd15);
        chk("sat stall_cnt16", 32'(cnt16), 32'd20);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
